// File: rtl/trng_pkg.sv
// Shared constants for the multi-channel TRNG entropy pool.
// Mode encodings, default word width and channel limit.
package trng_pkg;

    localparam logic TRNG_MODE_BLOCKING  = 1'b0;
    localparam logic TRNG_MODE_OVERWRITE = 1'b1;

    localparam int TRNG_DEFAULT_DBW = 32;
    localparam int TRNG_MAX_CH      = 8;

endpackage

// File: rtl/trng_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at ptr.
// ptr advances past the granted channel; holds when nothing is granted.
module trng_rr_arbiter
    import trng_pkg::*;
#(
    parameter int N_CH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [N_CH-1:0] req,
    output logic [N_CH-1:0] gnt
);

    localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] gnt_idx;
    logic             found;

    always_comb begin
        gnt     = '0;
        found   = 1'b0;
        idx     = ptr;
        gnt_idx = ptr;
        for (int i = 0; i < N_CH; i++) begin
            idx = PTR_W'((int'(ptr) + i) % N_CH);
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt_idx  = idx;
                gnt[idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (gnt_idx == PTR_W'(N_CH - 1)) ? '0 : gnt_idx + PTR_W'(1);
        end
    end

endmodule

// File: rtl/trng_pool_fifo.sv
// Multi-channel entropy pool: RR-arbitrated sources into one circular
// buffer, with overwrite or back-pressure behaviour when full.
module trng_pool_fifo
    import trng_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int DBW         = TRNG_DEFAULT_DBW,
    parameter int DEPTH       = 16,
    parameter int BLOCK_WORDS = 4,
    parameter int CNT_W       = 16,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_overwrite,
    input  logic                flush,
    input  logic [N_CH-1:0]     ch_valid,
    input  logic [N_CH*DBW-1:0] ch_data,
    output logic [N_CH-1:0]     ch_ready,
    input  logic                rd_req,
    output logic [DBW-1:0]      rd_data,
    output logic                rd_valid,
    output logic [ADDR_W:0]     occupancy,
    output logic                block_avail,
    output logic [CNT_W-1:0]    ovf_cnt
);

    (* ram_style = "block" *) logic [DBW-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] w_ptr;
    logic [ADDR_W-1:0] r_ptr;
    logic              full;
    logic              empty;
    logic              do_read;
    logic              do_write;
    logic              drop;
    logic              grant_en;
    logic [DBW-1:0]    wdata;

    assign full     = (occupancy == (ADDR_W+1)'(DEPTH));
    assign empty    = (occupancy == '0);
    assign do_read  = rd_req && !empty && !flush;
    assign grant_en = !reset && !flush &&
                      (!full || (cfg_overwrite == TRNG_MODE_OVERWRITE) || do_read);
    assign do_write = |ch_ready;
    // Full with no concurrent pop: the oldest word is sacrificed.
    assign drop     = do_write && full && !do_read;

    trng_rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (grant_en),
        .req   (ch_valid),
        .gnt   (ch_ready)
    );

    always_comb begin
        wdata = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_ready[i]) wdata = ch_data[i*DBW +: DBW];
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) mem[w_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr       <= '0;
            r_ptr       <= '0;
            occupancy   <= '0;
            ovf_cnt     <= '0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            block_avail <= 1'b0;
        end else if (flush) begin
            w_ptr       <= '0;
            r_ptr       <= '0;
            occupancy   <= '0;
            rd_valid    <= 1'b0;
            block_avail <= 1'b0;
        end else begin
            rd_valid    <= do_read;
            block_avail <= (occupancy >= (ADDR_W+1)'(BLOCK_WORDS));
            if (do_read) rd_data <= mem[r_ptr];
            if (do_write) w_ptr <= w_ptr + ADDR_W'(1);
            if (do_read || drop) r_ptr <= r_ptr + ADDR_W'(1);
            if (do_write && !do_read && !full) begin
                occupancy <= occupancy + (ADDR_W+1)'(1);
            end else if (do_read && !do_write) begin
                occupancy <= occupancy - (ADDR_W+1)'(1);
            end
            if (drop && (ovf_cnt != '1)) ovf_cnt <= ovf_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_trng_pool_fifo.sv
// Scoreboard bench for trng_pool_fifo: directed pushes/pops with a
// queue of expected read words checked by an independent monitor.
module tb_trng_pool_fifo;
    import trng_pkg::*;

    localparam int N_CH   = 2;
    localparam int DBW    = 32;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = 16;

    logic                clk;
    logic                reset;
    logic                cfg_overwrite;
    logic                flush;
    logic [N_CH-1:0]     ch_valid;
    logic [N_CH*DBW-1:0] ch_data;
    logic [N_CH-1:0]     ch_ready;
    logic                rd_req;
    logic [DBW-1:0]      rd_data;
    logic                rd_valid;
    logic [ADDR_W:0]     occupancy;
    logic                block_avail;
    logic [CNT_W-1:0]    ovf_cnt;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic        exp_pop;
    logic        want;

    trng_pool_fifo #(
        .N_CH        (2),
        .DBW         (32),
        .DEPTH       (16),
        .BLOCK_WORDS (4),
        .CNT_W       (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_overwrite (cfg_overwrite),
        .flush         (flush),
        .ch_valid      (ch_valid),
        .ch_data       (ch_data),
        .ch_ready      (ch_ready),
        .rd_req        (rd_req),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .occupancy     (occupancy),
        .block_avail   (block_avail),
        .ovf_cnt       (ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, check the combinational grant, advance.
    task automatic cyc(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                       input logic rr, input logic pop, input logic [31:0] ew,
                       input logic [1:0] er);
        ch_valid = v;
        ch_data  = {d1, d0};
        rd_req   = rr;
        exp_pop  = pop;
        if (pop) exp_q.push_back(ew);
        #1;
        chk("ch_ready", 32'(ch_ready), 32'(er));
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(2'b00, 0, 0, 1'b0, 1'b0, 0, 2'b00);
    endtask

    task automatic pop_exp(input logic [31:0] ew);
        cyc(2'b00, 0, 0, 1'b1, 1'b1, ew, 2'b00);
    endtask

    task automatic push0(input logic [31:0] d, input logic [1:0] er);
        cyc(2'b01, d, 0, 1'b0, 1'b0, 0, er);
    endtask

    always @(posedge clk) begin
        want = exp_pop;
        #1;
        chk("rd_valid", 32'(rd_valid), 32'(want));
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_data: got 0x%0h expected no word", rd_data);
            end else begin
                chk("rd_data", rd_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int na;
        int nb;
        clk           = 1'b0;
        reset         = 1'b1;
        cfg_overwrite = TRNG_MODE_BLOCKING;
        flush         = 1'b0;
        ch_valid      = '0;
        ch_data       = '0;
        rd_req        = 1'b0;
        exp_pop       = 1'b0;
        @(negedge clk);

        // Reset: grants suppressed, state cleared
        cyc(2'b11, 32'h1, 32'h2, 1'b1, 1'b0, 0, 2'b00);
        cyc(2'b11, 32'h1, 32'h2, 1'b1, 1'b0, 0, 2'b00);
        chk("rst_occ", 32'(occupancy), 0);
        chk("rst_ovf", 32'(ovf_cnt), 0);
        chk("rst_blk", 32'(block_avail), 0);
        chk("rst_rdata", rd_data, 0);
        reset = 1'b0;

        // 1: BLOCKING fill, 17th word stalls
        for (int n = 1; n <= 16; n++) push0(n, 2'b01);
        chk("t1_occ16", 32'(occupancy), 16);
        push0(17, 2'b00);
        push0(17, 2'b00);
        chk("t1_stall_occ", 32'(occupancy), 16);
        chk("t1_ovf", 32'(ovf_cnt), 0);
        for (int n = 1; n <= 16; n++) pop_exp(n);
        idle();
        chk("t1_empty", 32'(occupancy), 0);

        // 2: OVERWRITE, 20 pushes keep the newest 16
        cfg_overwrite = TRNG_MODE_OVERWRITE;
        for (int n = 1; n <= 20; n++) push0(n, 2'b01);
        chk("t2_occ", 32'(occupancy), 16);
        chk("t2_ovf", 32'(ovf_cnt), 4);
        for (int n = 5; n <= 20; n++) pop_exp(n);
        idle();
        chk("t2_empty", 32'(occupancy), 0);

        // 3: both channels, strict alternation from pointer 0
        reset = 1'b1;
        idle();
        reset = 1'b0;
        na = 0;
        nb = 0;
        for (int k = 0; k < 8; k++) begin
            cyc(2'b11, 32'hA000 + na, 32'hB000 + nb, 1'b0, 1'b0, 0,
                (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k % 2 == 0) na++;
            else nb++;
        end
        chk("t3_occ", 32'(occupancy), 8);
        for (int k = 0; k < 8; k++) begin
            pop_exp(((k % 2 == 0) ? 32'hA000 : 32'hB000) + 32'(k / 2));
        end
        idle();

        // 4: full in OVERWRITE, simultaneous push and pop
        for (int i = 0; i < 18; i++) push0(32'h100 + i, 2'b01);
        chk("t4_occ", 32'(occupancy), 16);
        chk("t4_ovf", 32'(ovf_cnt), 2);
        cyc(2'b01, 32'h1FF, 0, 1'b1, 1'b1, 32'h102, 2'b01);
        chk("t4_occ_same", 32'(occupancy), 16);
        chk("t4_ovf_same", 32'(ovf_cnt), 2);
        for (int i = 3; i < 18; i++) pop_exp(32'h100 + i);
        pop_exp(32'h1FF);
        idle();
        chk("t4_empty", 32'(occupancy), 0);

        // 5: block_avail threshold with one-cycle lag
        for (int i = 0; i < 3; i++) push0(32'h500 + i, 2'b01);
        chk("t5_blk3", 32'(block_avail), 0);
        push0(32'h503, 2'b01);
        chk("t5_occ4", 32'(occupancy), 4);
        chk("t5_blk_lag", 32'(block_avail), 0);
        idle();
        chk("t5_blk_set", 32'(block_avail), 1);
        pop_exp(32'h500);
        chk("t5_blk_hold", 32'(block_avail), 1);
        idle();
        chk("t5_blk_clr", 32'(block_avail), 0);

        // 6: flush at occupancy 7 with a read pending
        for (int i = 0; i < 4; i++) push0(32'h600 + i, 2'b01);
        chk("t6_occ7", 32'(occupancy), 7);
        chk("t6_blk", 32'(block_avail), 1);
        flush = 1'b1;
        cyc(2'b01, 32'h6FF, 0, 1'b1, 1'b0, 0, 2'b00);
        flush = 1'b0;
        chk("t6_flush_occ", 32'(occupancy), 0);
        chk("t6_flush_blk", 32'(block_avail), 0);
        chk("t6_ovf_kept", 32'(ovf_cnt), 2);
        cyc(2'b00, 0, 0, 1'b1, 1'b0, 0, 2'b00);
        chk("t6_empty_rd", 32'(occupancy), 0);
        cyc(2'b11, 32'h700, 32'h800, 1'b0, 1'b0, 0, 2'b10);
        idle();
        idle();
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
